// File: rtl/sensor_poll_scheduler.sv
// Sensor poll scheduler: host command decoding, round-robin continuous reads and a hold-off after each sensor read.
// Optional macro SCHED_TIMEOUT_EN adds a sensor_done watchdog in WAIT.
module sensor_poll_scheduler #(
  parameter int NUM_SENSORS    = 32,
  parameter int ADDR_W         = 5,
  parameter int START_CYCLES   = 10,
  parameter int HOLDOFF_CYCLES = 19200,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [7:0]             cmd_code,
  input  logic [7:0]             cmd_addr,
  output logic                   cmd_ready,
  output logic [ADDR_W-1:0]      sensor_sel,
  output logic                   sensor_start,
  input  logic                   sensor_done,
  input  logic                   sensor_error,
  input  logic [7:0]             temp_int,
  input  logic [7:0]             hum_int,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_cmd,
  output logic [7:0]             tx_addr,
  output logic [7:0]             tx_value,
  output logic [NUM_SENSORS-1:0] cont_temp,
  output logic [NUM_SENSORS-1:0] cont_hum
);

  localparam logic [2:0] S_SCAN   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  // Read kind equals the low bits of the host read codes 0x00..0x02.
  localparam logic [1:0] K_STATUS = 2'd0;
  localparam logic [1:0] K_TEMP   = 2'd1;
  localparam logic [1:0] K_HUM    = 2'd2;

  logic [2:0]             state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d, sel_q, sel_d;
  logic                   phase_q, phase_d;
  logic [NUM_SENSORS-1:0] ctemp_q, ctemp_d, chum_q, chum_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [1:0]             kind_q, kind_d;
  logic                   read_q, read_d, start_q, start_d, ready_q, ready_d, txv_q, txv_d;
  logic [7:0]             txc_q, txc_d, txa_q, txa_d, txval_q, txval_d;
  logic [ADDR_W-1:0]      idx_next_s, addr_s;
  logic                   map_bit_s, addr_ok_s;

  assign idx_next_s = (idx_q == ADDR_W'(NUM_SENSORS - 1)) ? {ADDR_W{1'b0}} : idx_q + ADDR_W'(1);
  assign map_bit_s  = phase_q ? chum_q[idx_q] : ctemp_q[idx_q];
  assign addr_ok_s  = ({24'd0, cmd_addr} < 32'(NUM_SENSORS));
  assign addr_s     = cmd_addr[ADDR_W-1:0];

  // Next-state and response computation for the scheduler FSM.
  always_comb begin
    state_d = state_q;  idx_d = idx_q;    phase_d = phase_q; sel_d = sel_q;
    ctemp_d = ctemp_q;  chum_d = chum_q;  cnt_d = cnt_q;     kind_d = kind_q;
    read_d  = read_q;   start_d = start_q; ready_d = 1'b0;   txv_d = txv_q;
    txc_d   = txc_q;    txa_d = txa_q;    txval_d = txval_q;
    case (state_q)
      S_SCAN: begin
        if (cmd_valid) begin
          ready_d = 1'b1;
          state_d = S_ACCEPT;
        end else begin
          if (phase_q) begin
            phase_d = 1'b0;
            idx_d   = idx_next_s;
          end else begin
            phase_d = 1'b1;
          end
          if (map_bit_s) begin
            sel_d   = idx_q;
            kind_d  = phase_q ? K_HUM : K_TEMP;
            start_d = 1'b1;
            cnt_d   = 32'd0;
            read_d  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_ACCEPT: begin
        txa_d   = cmd_addr;
        txval_d = 8'h00;
        txv_d   = 1'b1;
        read_d  = 1'b0;
        state_d = S_SEND;
        if (!addr_ok_s) begin
          txc_d = 8'hFE;
        end else begin
          case (cmd_code)
            8'h00, 8'h01, 8'h02: begin
              txv_d   = 1'b0;
              sel_d   = addr_s;
              kind_d  = cmd_code[1:0];
              start_d = 1'b1;
              cnt_d   = 32'd0;
              read_d  = 1'b1;
              state_d = S_START;
            end
            8'h03:   begin ctemp_d[addr_s] = 1'b1; txc_d = 8'h0C; end
            8'h04:   begin chum_d[addr_s]  = 1'b1; txc_d = 8'h0D; end
            8'h05:   begin ctemp_d[addr_s] = 1'b0; txc_d = 8'h0A; end
            8'h06:   begin chum_d[addr_s]  = 1'b0; txc_d = 8'h0B; end
            default: txc_d = 8'hFF;
          endcase
        end
      end
      S_START: begin
        if ((cnt_q + 32'd1) >= 32'(START_CYCLES)) begin
          start_d = 1'b0;
          cnt_d   = 32'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (sensor_done) begin
          txv_d   = 1'b1;
          txa_d   = 8'(sel_q);
          state_d = S_SEND;
          if (sensor_error) begin
            txc_d   = 8'h1F;
            txval_d = 8'h00;
          end else begin
            case (kind_q)
              K_TEMP:  begin txc_d = 8'h09; txval_d = temp_int; end
              K_HUM:   begin txc_d = 8'h08; txval_d = hum_int;  end
              default: begin txc_d = 8'h07; txval_d = 8'h00;    end
            endcase
          end
`ifdef SCHED_TIMEOUT_EN
        end else if ((cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
          txv_d   = 1'b1;
          txc_d   = 8'h1E;
          txa_d   = 8'(sel_q);
          txval_d = 8'h00;
          cnt_d   = 32'd0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`else
        // Waited-cycle count saturates; only the watchdog build acts on it.
        end else if ((cnt_q + 32'd1) < 32'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = cnt_q;
        end
`endif
      end
      S_SEND: begin
        if (tx_ready) begin
          txv_d   = 1'b0;
          cnt_d   = 32'd0;
          state_d = read_q ? S_HOLD : S_SCAN;
        end else begin
          state_d = S_SEND;
        end
      end
      S_HOLD: begin
        if ((cnt_q + 32'd1) >= 32'(HOLDOFF_CYCLES)) begin
          cnt_d   = 32'd0;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SCAN;  idx_q <= {ADDR_W{1'b0}}; phase_q <= 1'b0; sel_q <= {ADDR_W{1'b0}};
      ctemp_q <= {NUM_SENSORS{1'b0}}; chum_q <= {NUM_SENSORS{1'b0}};
      cnt_q   <= 32'd0;   kind_q <= K_STATUS; read_q <= 1'b0; start_q <= 1'b0;
      ready_q <= 1'b0;    txv_q <= 1'b0; txc_q <= 8'h00; txa_q <= 8'h00; txval_q <= 8'h00;
    end else begin
      state_q <= state_d; idx_q <= idx_d; phase_q <= phase_d; sel_q <= sel_d;
      ctemp_q <= ctemp_d; chum_q <= chum_d;
      cnt_q   <= cnt_d;   kind_q <= kind_d; read_q <= read_d; start_q <= start_d;
      ready_q <= ready_d; txv_q <= txv_d; txc_q <= txc_d; txa_q <= txa_d; txval_q <= txval_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign sensor_sel   = sel_q;
  assign sensor_start = start_q;
  assign tx_valid     = txv_q;
  assign tx_cmd       = txc_q;
  assign tx_addr      = txa_q;
  assign tx_value     = txval_q;
  assign cont_temp    = ctemp_q;
  assign cont_hum     = chum_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Randomized bench for sensor_poll_scheduler against a transaction-level reference model.
module tb_sensor_poll_scheduler;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int SC = 10;
  localparam int HO = 20;
  localparam int TO = 100;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [7:0]    cmd_code = 8'h00, cmd_addr = 8'h00;
  logic [AW-1:0] sensor_sel;
  logic          sensor_start, sensor_done = 1'b0, sensor_error = 1'b0;
  logic [7:0]    temp_int = 8'h00, hum_int = 8'h00;
  logic          tx_valid, tx_ready = 1'b0;
  logic [7:0]    tx_cmd, tx_addr, tx_value;
  logic [N-1:0]  cont_temp, cont_hum;

  int n_vec = 0, n_bad = 0;
  logic [N-1:0] m_temp = '0, m_hum = '0;

  sensor_poll_scheduler #(.NUM_SENSORS(N), .ADDR_W(AW), .START_CYCLES(SC),
                          .HOLDOFF_CYCLES(HO), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .sensor_sel(sensor_sel), .sensor_start(sensor_start),
    .sensor_done(sensor_done), .sensor_error(sensor_error), .temp_int(temp_int), .hum_int(hum_int),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cmd(tx_cmd), .tx_addr(tx_addr), .tx_value(tx_value),
    .cont_temp(cont_temp), .cont_hum(cont_hum));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response rules straight from the command table.
  function automatic logic [23:0] resp_rule(input logic [7:0] code, input logic [7:0] addr,
                                            input logic err, input logic [7:0] t, input logic [7:0] h);
    if (addr >= N) return {8'hFE, addr, 8'h00};
    case (code)
      8'h00:   return {(err ? 8'h1F : 8'h07), addr, 8'h00};
      8'h01:   return err ? {8'h1F, addr, 8'h00} : {8'h09, addr, t};
      8'h02:   return err ? {8'h1F, addr, 8'h00} : {8'h08, addr, h};
      8'h03:   return {8'h0C, addr, 8'h00};
      8'h04:   return {8'h0D, addr, 8'h00};
      8'h05:   return {8'h0A, addr, 8'h00};
      8'h06:   return {8'h0B, addr, 8'h00};
      default: return {8'hFF, addr, 8'h00};
    endcase
  endfunction

  function automatic bit is_read(input logic [7:0] code, input logic [7:0] addr);
    return (addr < N) && (code <= 8'h02);
  endfunction

  function automatic void model_cfg(input logic [7:0] code, input logic [7:0] addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    if (addr < N) begin
      case (code)
        8'h03:   m_temp[a] = 1'b1;
        8'h04:   m_hum[a]  = 1'b1;
        8'h05:   m_temp[a] = 1'b0;
        8'h06:   m_hum[a]  = 1'b0;
        default: ;
      endcase
    end
  endfunction

  task automatic check_maps();
    check_eq("cont_temp", cont_temp, m_temp);
    check_eq("cont_hum", cont_hum, m_hum);
  endtask

  // Called at a negedge; exp_lat = expected clock edges from cmd_valid to cmd_ready.
  task automatic send_cmd(input logic [7:0] code, input logic [7:0] addr, input int exp_lat, input bit rd);
    int n;
    cmd_valid = 1'b1; cmd_code = code; cmd_addr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 400);
    cmd_valid = 1'b0;
    check_eq("cmd_ready_latency", n, exp_lat);
    @(negedge clk);
    check_eq("cmd_ready_pulse", cmd_ready, 1'b0);
    if (rd) check_eq("read_start_after_accept", sensor_start, 1'b1);
    else    check_eq("cfg_to_tx_latency", tx_valid, 1'b1);
  endtask

  task automatic run_read(input logic [AW-1:0] exp_sel, input logic err, input logic [7:0] t,
                          input logic [7:0] h, input int delay, input bit give_done);
    int n;
    n = 0;
    while (!sensor_start && n < 400) begin @(negedge clk); n++; end
    check_eq("start_seen", sensor_start, 1'b1);
    n = 0;
    while (sensor_start && n < 400) begin
      check_eq("sel_during_start", sensor_sel, exp_sel);
      @(negedge clk); n++;
    end
    check_eq("start_width", n, SC);
    if (give_done) begin
      repeat (delay) @(negedge clk);
      check_eq("sel_in_wait", sensor_sel, exp_sel);
      sensor_done = 1'b1; sensor_error = err; temp_int = t; hum_int = h;
      @(negedge clk);
      sensor_done = 1'b0; sensor_error = 1'($urandom); temp_int = ~t; hum_int = ~h;
    end
  endtask

  task automatic recv_resp(input logic [23:0] exp, input int stall);
    int n;
    n = 0;
    while (!tx_valid && n < 400) begin @(negedge clk); n++; end
    check_eq("tx_valid_seen", tx_valid, 1'b1);
    check_eq("tx_cmd", tx_cmd, exp[23:16]);
    check_eq("tx_addr", tx_addr, exp[15:8]);
    check_eq("tx_value", tx_value, exp[7:0]);
    repeat (stall) begin
      @(negedge clk);
      check_eq("stall_valid", tx_valid, 1'b1);
      check_eq("stall_fields", {tx_cmd, tx_addr, tx_value}, exp);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check_eq("single_transfer", tx_valid, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_start", sensor_start, 1'b0);
    check_eq("rst_sel", sensor_sel, '0);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_tx_fields", {tx_cmd, tx_addr, tx_value}, 24'h0);
    check_eq("rst_cont_temp", cont_temp, '0);
    check_eq("rst_cont_hum", cont_hum, '0);
  endtask

  initial begin
    logic [7:0] code, addr, t, h;
    logic       err;
    bit         rd, prev_rd, any_start, any_tx;
    int         last_pos, p;
    logic [7:0] fx_code [4] = '{8'h01, 8'h00, 8'h07, 8'h01};
    logic [7:0] fx_addr [4] = '{8'h02, 8'h03, 8'h01, 8'h09};
    logic       fx_err  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reset and idle: nothing may start or transmit.
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    any_start = 1'b0; any_tx = 1'b0;
    repeat (50) begin
      @(negedge clk);
      any_start |= sensor_start;
      any_tx    |= tx_valid;
    end
    check_eq("idle_no_start", any_start, 1'b0);
    check_eq("idle_no_tx", any_tx, 1'b0);
    check_maps();

    // Host commands with empty maps: fixed corner cases first, then random.
    prev_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t = 8'($urandom); h = 8'($urandom);
      if (i < 4) begin
        code = fx_code[i]; addr = fx_addr[i]; err = fx_err[i];
        if (i == 0) t = 8'h19;
      end else begin
        int r;
        r = $urandom_range(0, 9);
        addr = 8'($urandom_range(0, 7));
        err  = ($urandom_range(0, 3) == 0);
        if (r < 6)      code = 8'(r % 3);
        else if (r < 8) begin code = 8'($urandom_range(3, 6)); addr = 8'($urandom_range(4, 200)); end
        else            code = 8'($urandom_range(7, 255));
      end
      rd = is_read(code, addr);
      send_cmd(code, addr, prev_rd ? HO + 1 : 1, rd);
      if (rd) run_read(addr[AW-1:0], err, t, h, $urandom_range(0, 4), 1'b1);
      recv_resp(resp_rule(code, addr, rd ? err : 1'b0, t, h), (i == 0) ? 15 : $urandom_range(0, 3));
      check_maps();
      prev_rd = rd;
    end

    // Continuous reads: reset puts the scan at sensor 0 / TEMP, then configure back-to-back.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    m_temp = '0; m_hum = '0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      begin code = 8'h03; addr = 8'h01; end
      else if (i == 1) begin code = 8'h04; addr = 8'h01; end
      else             begin code = 8'($urandom_range(3, 4)); addr = 8'($urandom_range(0, N - 1)); end
      send_cmd(code, addr, 1, 1'b0);
      recv_resp(resp_rule(code, addr, 1'b0, 8'h00, 8'h00), $urandom_range(0, 2));
      model_cfg(code, addr);
      check_maps();
    end
    last_pos = -1;
    for (int i = 0; i < 14; i++) begin
      p = 0;
      for (int k = 1; k <= 2 * N; k++) begin
        p = (last_pos + k) % (2 * N);
        if (((p % 2) == 0) ? m_temp[p / 2] : m_hum[p / 2]) break;
      end
      err = ($urandom_range(0, 4) == 0);
      t = (i < 2) ? 8'h15 : 8'($urandom);
      h = (i < 2) ? 8'h3C : 8'($urandom);
      run_read(AW'(p / 2), err, t, h, $urandom_range(0, 3), 1'b1);
      recv_resp(resp_rule((p % 2) ? 8'h02 : 8'h01, 8'(p / 2), err, t, h), $urandom_range(0, 2));
      last_pos = p;
      if ($urandom_range(0, 2) == 0) begin
        code = 8'($urandom_range(0, 6)); addr = 8'($urandom_range(0, N - 1));
        if ((code == 8'h05 || code == 8'h06) && ($countones({m_temp, m_hum}) <= 1)) code = code - 8'h02;
        rd = is_read(code, addr);
        t = 8'($urandom); h = 8'($urandom); err = ($urandom_range(0, 3) == 0);
        send_cmd(code, addr, HO + 1, rd);
        if (rd) run_read(addr[AW-1:0], err, t, h, $urandom_range(0, 3), 1'b1);
        recv_resp(resp_rule(code, addr, rd ? err : 1'b0, t, h), $urandom_range(0, 2));
        model_cfg(code, addr);
        check_maps();
      end
    end

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: no sensor_done, expect 0x1E after TO cycles of WAIT.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_temp = '0; m_hum = '0;
    send_cmd(8'h01, 8'h02, 1, 1'b1);
    run_read(AW'(2), 1'b0, 8'h00, 8'h00, 0, 1'b0);
    p = 0;
    while (!tx_valid && p < 1000) begin p++; @(negedge clk); end
    check_eq("timeout_wait_cycles", p, TO);
    recv_resp({8'h1E, 8'h02, 8'h00}, 0);
`endif

    // Reset in the middle of WAIT returns every output to its reset value.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_temp = '0; m_hum = '0;
    send_cmd(8'h03, 8'h03, 1, 1'b0);
    recv_resp({8'h0C, 8'h03, 8'h00}, 0);
    model_cfg(8'h03, 8'h03);
    check_maps();
    send_cmd(8'h02, 8'h01, 1, 1'b1);
    run_read(AW'(1), 1'b0, 8'h00, 8'h00, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
